// File: rtl/inst_fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM state encodings
// and the default boot address.
package inst_fetch_pkg;

  localparam int unsigned IFU_XLEN = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

  typedef enum logic [2:0] {
    IFU_BOOT = 3'd0,
    IFU_REQ  = 3'd1,
    IFU_WAIT = 3'd2,
    IFU_HOLD = 3'd3,
    IFU_HALT = 3'd4
  } ifu_state_e;

endpackage

// File: rtl/ifu_pc_reg.sv
// PC register: async reset to RESET_PC, loads either a redirect target
// or pc+4 when load_en is high. Ports: clk, rst_n, load_en, sel_redir,
// redir_pc (target), pc (current value).
module ifu_pc_reg #(
  parameter int unsigned XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_en,
  input  logic            sel_redir,
  input  logic [XLEN-1:0] redir_pc,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      pc_d = sel_redir ? redir_pc : pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: one outstanding imem request, result held for the decoder
// on a valid/ready channel; execute-stage redirects and ebreak halt.
// Ports: clk, rst_n, imem_req_{valid,ready,addr}, imem_rsp_{valid,data},
// inst_{valid,ready}, inst, inst_pc, redirect_{valid,pc}, halt, halted,
// fetch_err. Optional: IFU_ALIGN_CHK_EN halts on misaligned redirects.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned XLEN     = IFU_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            halted,
  output logic            fetch_err
);

  ifu_state_e      state_d, state_q;
  logic            drop_d, drop_q;
  logic [XLEN-1:0] inst_d, inst_q;
  logic [XLEN-1:0] ipc_d, ipc_q;
  logic            pc_ld, pc_sel;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] redir_tgt;

`ifdef IFU_ALIGN_CHK_EN
  logic err_d, err_q;
  logic redir_bad;
  assign redir_tgt = redirect_pc;
  assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign redir_tgt = redirect_pc & ~XLEN'(3);
`endif

  ifu_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (pc_ld),
    .sel_redir (pc_sel),
    .redir_pc  (redir_tgt),
    .pc        (pc)
  );

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    pc_ld   = 1'b0;
    pc_sel  = 1'b0;
`ifdef IFU_ALIGN_CHK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IFU_BOOT: state_d = IFU_REQ;
      IFU_REQ: begin
        if (redirect_valid) begin
          pc_ld  = 1'b1;
          pc_sel = 1'b1;
          // request already went out to the old pc; its reply is stale
          if (imem_req_ready) begin
            state_d = IFU_WAIT;
            drop_d  = 1'b1;
          end
        end else if (imem_req_ready) begin
          state_d = IFU_WAIT;
        end
      end
      IFU_WAIT: begin
        if (redirect_valid) begin
          pc_ld  = 1'b1;
          pc_sel = 1'b1;
          // a reply in this same cycle is the outstanding one: consume it
          if (imem_rsp_valid) begin
            state_d = IFU_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = IFU_REQ;
          end else begin
            inst_d  = imem_rsp_data;
            ipc_d   = pc;
            state_d = IFU_HOLD;
          end
        end
      end
      IFU_HOLD: begin
        if (redirect_valid) begin
          pc_ld   = 1'b1;
          pc_sel  = 1'b1;
          state_d = IFU_REQ;
        end else if (inst_ready) begin
          pc_ld   = 1'b1;
          state_d = halt ? IFU_HALT : IFU_REQ;
        end
      end
      IFU_HALT: state_d = IFU_HALT;
      default:  state_d = IFU_BOOT;
    endcase
`ifdef IFU_ALIGN_CHK_EN
    if (redir_bad &&
        (state_q == IFU_REQ || state_q == IFU_WAIT ||
         state_q == IFU_HOLD)) begin
      pc_ld   = 1'b0;
      drop_d  = 1'b0;
      err_d   = 1'b1;
      state_d = IFU_HALT;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IFU_BOOT;
      drop_q  <= 1'b0;
      inst_q  <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
    end
  end

`ifdef IFU_ALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

  assign imem_req_valid = (state_q == IFU_REQ);
  assign imem_req_addr  = pc;
  assign inst_valid     = (state_q == IFU_HOLD);
  assign inst           = inst_q;
  assign inst_pc        = ipc_q;
  assign halted         = (state_q == IFU_HALT);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: per-cycle vector table for the main
// flow and redirects, hand sequences for halt, reset and alignment.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;
  logic        fetch_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .halted         (halted),
    .fetch_err      (fetch_err)
  );

  typedef struct {
    logic        rr;
    logic        sv;
    logic [31:0] sd;
    logic        ir;
    logic        xv;
    logic [31:0] xp;
    logic        hl;
    logic        e_rv;
    logic [31:0] e_ad;
    logic        e_iv;
    logic [31:0] e_in;
    logic [31:0] e_pc;
    logic        e_hl;
  } vec_t;

  vec_t v[27];

  function automatic vec_t mk(
    input logic rr, input logic sv, input logic [31:0] sd,
    input logic ir, input logic xv, input logic [31:0] xp,
    input logic hl, input logic e_rv, input logic [31:0] e_ad,
    input logic e_iv, input logic [31:0] e_in,
    input logic [31:0] e_pc, input logic e_hl);
    vec_t r;
    r.rr = rr; r.sv = sv; r.sd = sd; r.ir = ir;
    r.xv = xv; r.xp = xp; r.hl = hl;
    r.e_rv = e_rv; r.e_ad = e_ad; r.e_iv = e_iv;
    r.e_in = e_in; r.e_pc = e_pc; r.e_hl = e_hl;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;
  endtask

  task automatic chk_zero(input string p);
    chk({p, ".req_valid"}, {31'b0, imem_req_valid}, 32'h0);
    chk({p, ".inst_valid"}, {31'b0, inst_valid}, 32'h0);
    chk({p, ".inst"}, inst, 32'h0);
    chk({p, ".inst_pc"}, inst_pc, 32'h0);
    chk({p, ".halted"}, {31'b0, halted}, 32'h0);
    chk({p, ".fetch_err"}, {31'b0, fetch_err}, 32'h0);
  endtask

  initial begin
    // inputs: rr sv sd ir xv xp hl | expected: rv addr iv inst pc halted
    v[0]  = mk(0,0,0,0,0,0,0, 0,0,0,0,0,0);
    v[1]  = mk(1,0,0,0,0,0,0, 1,32'h80000000,0,0,0,0);
    v[2]  = mk(0,1,32'h00100093,0,0,0,0, 0,0,0,0,0,0);
    v[3]  = mk(0,0,0,1,0,0,0, 0,0,1,32'h00100093,32'h80000000,0);
    v[4]  = mk(1,0,0,0,0,0,0,
               1,32'h80000004,0,32'h00100093,32'h80000000,0);
    v[5]  = mk(0,1,32'h00200113,0,0,0,0,
               0,0,0,32'h00100093,32'h80000000,0);
    for (int i = 6; i <= 10; i++)
      v[i] = mk(0,0,0,0,0,0,0,
                0,0,1,32'h00200113,32'h80000004,0);
    v[11] = mk(0,0,0,1,0,0,0, 0,0,1,32'h00200113,32'h80000004,0);
    v[12] = mk(1,0,0,0,0,0,0,
               1,32'h80000008,0,32'h00200113,32'h80000004,0);
    v[13] = mk(0,0,0,0,1,32'h80000100,0,
               0,0,0,32'h00200113,32'h80000004,0);
    v[14] = mk(0,1,32'hDEADBEEF,0,0,0,0,
               0,0,0,32'h00200113,32'h80000004,0);
    v[15] = mk(1,0,0,0,0,0,0,
               1,32'h80000100,0,32'h00200113,32'h80000004,0);
    v[16] = mk(0,1,32'h00300193,0,0,0,0,
               0,0,0,32'h00200113,32'h80000004,0);
    v[17] = mk(0,0,0,1,1,32'h80000200,0,
               0,0,1,32'h00300193,32'h80000100,0);
    v[18] = mk(1,0,0,0,0,0,0,
               1,32'h80000200,0,32'h00300193,32'h80000100,0);
    v[19] = mk(0,1,32'hBAD0BAD0,0,1,32'h80000300,0,
               0,0,0,32'h00300193,32'h80000100,0);
    v[20] = mk(0,1,32'h22222222,0,1,32'h80000400,0,
               1,32'h80000300,0,32'h00300193,32'h80000100,0);
    v[21] = mk(1,0,0,0,1,32'h80000500,0,
               1,32'h80000400,0,32'h00300193,32'h80000100,0);
    v[22] = mk(0,1,32'h11111111,0,0,0,0,
               0,0,0,32'h00300193,32'h80000100,0);
    v[23] = mk(1,0,0,0,0,0,0,
               1,32'h80000500,0,32'h00300193,32'h80000100,0);
    v[24] = mk(0,1,32'h00400213,0,0,0,0,
               0,0,0,32'h00300193,32'h80000100,0);
    v[25] = mk(0,0,0,1,0,0,1,
               0,0,1,32'h00400213,32'h80000500,0);
    v[26] = mk(0,0,0,0,0,0,0,
               0,0,0,32'h00400213,32'h80000500,1);

    idle();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 27; i++) begin
      chk($sformatf("v%0d.req_valid", i),
          {31'b0, imem_req_valid}, {31'b0, v[i].e_rv});
      if (v[i].e_rv)
        chk($sformatf("v%0d.req_addr", i), imem_req_addr, v[i].e_ad);
      chk($sformatf("v%0d.inst_valid", i),
          {31'b0, inst_valid}, {31'b0, v[i].e_iv});
      chk($sformatf("v%0d.inst", i), inst, v[i].e_in);
      chk($sformatf("v%0d.inst_pc", i), inst_pc, v[i].e_pc);
      chk($sformatf("v%0d.halted", i),
          {31'b0, halted}, {31'b0, v[i].e_hl});
      chk($sformatf("v%0d.fetch_err", i), {31'b0, fetch_err}, 32'h0);
      imem_req_ready = v[i].rr;
      imem_rsp_valid = v[i].sv;
      imem_rsp_data  = v[i].sd;
      inst_ready     = v[i].ir;
      redirect_valid = v[i].xv;
      redirect_pc    = v[i].xp;
      halt           = v[i].hl;
      @(negedge clk);
    end

    // halted is sticky and ignores every input for 20 cycles
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("halt%0d.halted", i), {31'b0, halted}, 32'h1);
      chk($sformatf("halt%0d.req_valid", i),
          {31'b0, imem_req_valid}, 32'h0);
      chk($sformatf("halt%0d.inst_valid", i),
          {31'b0, inst_valid}, 32'h0);
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hCAFEF00D;
      inst_ready     = 1'b1;
      redirect_valid = (i == 3);
      redirect_pc    = 32'h80000800;
      @(negedge clk);
    end
    idle();

    // reset out of HALT, fetch one inst, then reset again mid-WAIT
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst1.halted", {31'b0, halted}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst1.req_addr", imem_req_addr, 32'h80000000);
    imem_req_ready = 1'b1;
    @(negedge clk);
    idle();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h00A00513;
    @(negedge clk);
    idle();
    chk("rst1.inst", inst, 32'h00A00513);
    inst_ready = 1'b1;
    @(negedge clk);
    idle();
    chk("rst1.next_addr", imem_req_addr, 32'h80000004);
    imem_req_ready = 1'b1;
    @(negedge clk);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_wait");
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hFFFFFFFF;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("late.req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("late.req_addr", imem_req_addr, 32'h80000000);
    chk("late.inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("late.inst", inst, 32'h0);
    @(negedge clk);
    chk("late2.req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("late2.inst_valid", {31'b0, inst_valid}, 32'h0);
    idle();
    imem_req_ready = 1'b1;
    @(negedge clk);
    idle();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h00500293;
    @(negedge clk);
    idle();
    chk("refetch.inst", inst, 32'h00500293);
    chk("refetch.inst_pc", inst_pc, 32'h80000000);
    inst_ready = 1'b1;
    @(negedge clk);
    idle();
    chk("refetch.next_addr", imem_req_addr, 32'h80000004);

    // misaligned redirect while a request is pending acceptance
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80000102;
    @(negedge clk);
    idle();
    for (int i = 0; i < 3; i++) begin
`ifdef IFU_ALIGN_CHK_EN
      chk($sformatf("mis%0d.fetch_err", i), {31'b0, fetch_err}, 32'h1);
      chk($sformatf("mis%0d.halted", i), {31'b0, halted}, 32'h1);
      chk($sformatf("mis%0d.req_valid", i),
          {31'b0, imem_req_valid}, 32'h0);
`else
      chk($sformatf("mis%0d.fetch_err", i), {31'b0, fetch_err}, 32'h0);
      chk($sformatf("mis%0d.halted", i), {31'b0, halted}, 32'h0);
      chk($sformatf("mis%0d.req_valid", i),
          {31'b0, imem_req_valid}, 32'h1);
      chk($sformatf("mis%0d.req_addr", i), imem_req_addr, 32'h80000100);
`endif
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
